// File: rtl/fir_decim_requant.sv
// Post-FIR stage: drops the filter start-up transient, decimates, rounds and
// saturates each kept sample to OUT_WIDTH bits, and buffers the results in a
// first-word-fall-through FIFO for a back-pressuring consumer.
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. out_valid depends only on FIFO occupancy, and out_data holds
// the FIFO head steady until it is popped.
module fir_decim_requant #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 10,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 39,
  parameter int FIFO_DEPTH = 8   // power of two, at least 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 clr,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_seen,
  output logic                 ovf,
  output logic [0:0]           dbg_state
);

  localparam logic [0:0] S_WARMUP = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  // Rounding offset and clamp limits, expressed at the widened add width.
  localparam logic signed [IN_WIDTH:0] HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WIDTH:0] QMAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] QMIN = ~QMAX;

  logic [0:0]     state;
  logic [WCW-1:0] warm_cnt;
  logic [WCW-1:0] warm_nxt;
  logic [PW-1:0]  phase;
  logic           keep;

  assign dbg_state = state;
  assign warm_nxt  = warm_cnt + 1'b1;
  assign keep      = in_valid & (state == S_RUN) & (phase == '0);

  // Warm-up counting and decimation phase; frozen while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (WARMUP == 0) ? S_RUN : S_WARMUP;
      warm_cnt <= '0;
      phase    <= '0;
    end else if (in_valid) begin
      if (state == S_WARMUP) begin
        warm_cnt <= warm_nxt;
        if (warm_nxt == WCW'(WARMUP)) state <= S_RUN;
      end else begin
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  logic signed [IN_WIDTH:0] t;
  logic signed [IN_WIDTH:0] q;
  logic [OUT_WIDTH-1:0]     q_sat;
  logic                     clamp;

  // Round half toward +inf, then clamp to the signed output range.
  always_comb begin
    t     = $signed({din[IN_WIDTH-1], din}) + HALF;
    q     = t >>> SHIFT;
    clamp = 1'b0;
    q_sat = q[OUT_WIDTH-1:0];
    if (q > QMAX) begin
      q_sat = QMAX[OUT_WIDTH-1:0];
      clamp = 1'b1;
    end else if (q < QMIN) begin
      q_sat = QMIN[OUT_WIDTH-1:0];
      clamp = 1'b1;
    end
  end

  logic                 r_valid;
  logic [OUT_WIDTH-1:0] r_data;

  // Stage R: registers the requantised kept sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= keep;
      if (keep) r_data <= q_sat;
    end
  end

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 pop;
  logic                 push;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = r_valid & (~full | pop);
  assign out_data  = out_valid ? mem[rptr] : '0;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= r_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sticky flags; a set event in the same cycle as clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_seen <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (keep & clamp) sat_seen <= 1'b1;
      else if (clr)     sat_seen <= 1'b0;
      if (r_valid & full & ~pop) ovf <= 1'b1;
      else if (clr)              ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: directed scenarios plus a randomized run
// against a sample-level arithmetic model of the block.
module tb_fir_decim_requant;

  localparam int IW  = 32;
  localparam int OW  = 16;
  localparam int SH  = 10;
  localparam int DEC = 4;
  localparam int WU  = 39;
  localparam int FD  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] din;
  logic          clr;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sat_seen;
  logic          ovf;
  logic [0:0]    dbg_state;

  fir_decim_requant #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DECIM(DEC),
    .WARMUP(WU), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr(clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_seen(sat_seen), .ovf(ovf), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int            m_warm;
  int            m_idx;
  logic          exp_sat;

  // Every accepted output word, in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
  end

  // Reference requantisation: floor((v + 2^(SH-1)) / 2^SH), then clamp.
  function automatic longint ref_q(input longint v, output logic c);
    longint t, q, lim;
    t = v + (longint'(1) << (SH - 1));
    if (t >= 0) q = t / (longint'(1) << SH);
    else        q = -((-t + (longint'(1) << SH) - 1) / (longint'(1) << SH));
    lim = (longint'(1) << (OW - 1));
    c = 1'b0;
    if (q > lim - 1) begin q = lim - 1; c = 1'b1; end
    if (q < -lim)    begin q = -lim;    c = 1'b1; end
    return q;
  endfunction

  task automatic model_reset();
    m_warm = 0; m_idx = 0; exp_sat = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  // Drive one valid sample for one cycle and feed it to the model.
  task automatic send(input logic [IW-1:0] v);
    longint q; logic c;
    in_valid = 1'b1; din = v;
    if (m_warm < WU) m_warm++;
    else begin
      if (m_idx % DEC == 0) begin
        q = ref_q(longint'($signed(v)), c);
        exp_q.push_back(q[OW-1:0]);
        if (c) exp_sat = 1'b1;
      end
      m_idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; din = '0; clr = 1'b0; out_ready = 1'b1;
    settle(2);
    rst = 1'b0;
    model_reset();
    settle(1);
  endtask

  task automatic warm();
    repeat (WU) send(IW'($urandom()));
  endtask

  // A small non-saturating filler for discarded decimation phases.
  function automatic logic [IW-1:0] filler();
    return IW'($urandom_range(0, 2000000)) - IW'(1000000);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; din = '0; clr = 1'b0; out_ready = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (sat_seen !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got sat=%b ovf=%b exp=0,0", sat_seen, ovf); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    settle(2);
  endtask

  task automatic test_warmup();
    do_reset();
    repeat (WU - 1) send(IW'(1024));
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL warmup_state_early got=%b exp=0", dbg_state); end
    send(IW'(1024));
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL warmup_state_run got=%b exp=1", dbg_state); end
    settle(3);
    checks++; if (got_q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL warmup_discard got=%0d words exp=0", got_q.size()); end
    send(IW'(2048));
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd2) begin errors++; $display("FAIL latency_2 got v=%b d=%0d exp v=1 d=2", out_valid, $signed(out_data)); end
    settle(3);
  endtask

  task automatic test_decimation();
    int tbl[3] = '{0, 4, 8};
    do_reset(); warm();
    for (int k = 0; k < 12; k++) send(IW'(k * 1024));
    settle(4);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL decim_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (int'($signed(got_q[i])) !== tbl[i]) begin errors++; $display("FAIL decim_%0d got=%0d exp=%0d", i, $signed(got_q[i]), tbl[i]); end
    end
  endtask

  task automatic test_rounding();
    int vin[6] = '{1536, 1535, -1536, -1537, 511, 512};
    int tbl[6] = '{2, 1, -1, -2, 0, 1};
    do_reset(); warm();
    for (int i = 0; i < 6; i++) begin
      send(IW'(vin[i]));
      repeat (DEC - 1) send(filler());
    end
    settle(4);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL round_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (int'($signed(got_q[i])) !== tbl[i]) begin errors++; $display("FAIL round_%0d din=%0d got=%0d exp=%0d", i, vin[i], $signed(got_q[i]), tbl[i]); end
    end
    checks++; if (sat_seen !== 1'b0) begin errors++; $display("FAIL round_no_sat got=%b exp=0", sat_seen); end
  endtask

  task automatic test_saturation();
    do_reset(); warm();
    send(IW'(1 << 26)); repeat (DEC - 1) send(filler());
    send(-IW'(1 << 26)); repeat (DEC - 1) send(filler());
    settle(4);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL sat_count got=%0d exp=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h7fff || got_q[1] !== 16'h8000) begin errors++; $display("FAIL sat_values got=%h,%h exp=7fff,8000", got_q[0], got_q[1]); end
    end
    checks++; if (sat_seen !== 1'b1) begin errors++; $display("FAIL sat_seen got=%b exp=1", sat_seen); end
    clr = 1'b1; settle(1); clr = 1'b0;
    checks++; if (sat_seen !== 1'b0) begin errors++; $display("FAIL sat_clr got=%b exp=0", sat_seen); end
    // clr in the same cycle as a saturating kept sample: set wins
    clr = 1'b1; send(IW'(1 << 27)); clr = 1'b0;
    checks++; if (sat_seen !== 1'b1) begin errors++; $display("FAIL sat_set_wins got=%b exp=1", sat_seen); end
    settle(3);
  endtask

  task automatic test_backpressure();
    do_reset(); warm();
    out_ready = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      send(IW'(v * 1024)); repeat (DEC - 1) send(filler());
    end
    settle(2);
    checks++; if (ovf !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_ovf got ovf=%b v=%b exp 1,1", ovf, out_valid); end
    out_ready = 1'b1;
    settle(12);
    checks++; if (got_q.size() != 8 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_count got=%0d v=%b exp=8 v=0", got_q.size(), out_valid); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (int'(got_q[i]) !== i + 1) begin errors++; $display("FAIL bp_word_%0d got=%0d exp=%0d", i, got_q[i], i + 1); end
    end
    clr = 1'b1; settle(1); clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
  endtask

  task automatic test_full_pop();
    do_reset(); warm();
    out_ready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      send(IW'(v * 1024)); repeat (DEC - 1) send(filler());
    end
    send(IW'(9 * 1024));
    out_ready = 1'b1;        // pop lands on the 9th sample's FIFO-write edge
    settle(1);
    out_ready = 1'b0;
    repeat (DEC - 1) send(filler());
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b exp=0", ovf); end
    out_ready = 1'b1;
    settle(12);
    checks++; if (got_q.size() != 9) begin errors++; $display("FAIL fullpop_count got=%0d exp=9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++; if (int'(got_q[i]) !== i + 1) begin errors++; $display("FAIL fullpop_word_%0d got=%0d exp=%0d", i, got_q[i], i + 1); end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset(); warm();
    out_ready = 1'b0;
    send(IW'(1 << 26)); repeat (DEC - 1) send(filler());
    send(IW'(3 * 1024)); repeat (DEC - 1) send(filler());
    send(IW'(4 * 1024));
    settle(3);
    checks++; if (out_valid !== 1'b1 || sat_seen !== 1'b1) begin errors++; $display("FAIL midrun_pre got v=%b sat=%b exp 1,1", out_valid, sat_seen); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || sat_seen !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL midrun_rst got v=%b sat=%b ovf=%b exp 0,0,0", out_valid, sat_seen, ovf); end
    settle(1);
    rst = 1'b0; model_reset(); out_ready = 1'b1;
    repeat (WU) send(IW'(7 * 1024));
    settle(4);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrun_warm got=%0d words exp=0", got_q.size()); end
    send(IW'(5 * 1024));
    settle(4);
    checks++; if (got_q.size() != 1 || got_q[0] !== 16'd5) begin errors++; $display("FAIL midrun_first got n=%0d exp one word of 5", got_q.size()); end
  endtask

  task automatic test_random();
    logic [IW-1:0] v;
    do_reset(); warm();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) v = IW'($urandom());
      else v = IW'($urandom_range(0, 67108863)) - IW'(33554432);
      if ($urandom_range(0, 4) == 0) settle(1);
      else send(v);
    end
    out_ready = 1'b1;
    settle(16);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (sat_seen !== exp_sat || ovf !== 1'b0) begin errors++; $display("FAIL rand_flags got sat=%b ovf=%b exp sat=%b ovf=0", sat_seen, ovf, exp_sat); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_decimation();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_requant.md
# fir_decim_requant

Post-filter stage placed directly downstream of the 32-tap FIR filter. It takes the filter's 32-bit signed output stream, discards the start-up transient, and decimates by a fixed factor. Each kept sample is rounded and saturated to 16 bits and buffered in a small first-word-fall-through FIFO behind a valid/ready handshake, so a back-pressuring consumer can take the result.

## Interface
- IN_WIDTH, 32: width of signed input sample (FIR output)
- OUT_WIDTH, 16: width of signed output sample
- SHIFT, 10: right-shift applied during requantisation (≥1)
- DECIM, 4: decimation factor (≥1; 1 = no decimation)
- WARMUP, 39: number of valid input samples discarded after reset (FIR latency 8 + 31 taps to fill)
- FIFO_DEPTH, 8: output FIFO entries (power of two)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  din carries a new FIR output this cycle
- din  input  IN_WIDTH  signed FIR output sample
- clr  input  1  synchronous clear of sticky flags only
- out_data  output  OUT_WIDTH  signed requantised sample (FIFO head)
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready
- sat_seen  output  1  sticky: at least one sample saturated
- ovf  output  1  sticky: at least one sample dropped because FIFO full

## Operation
- Reset values: out_data=0, out_valid=0, sat_seen=0, ovf=0; FIFO empty; state WARMUP; warm-up counter=0; phase=0.
- States:
  - WARMUP: each in_valid increments the warm-up counter and the sample is discarded. On the in_valid that brings the count to WARMUP, go to RUN; that sample is also discarded. WARMUP=0 resets directly into RUN.
  - RUN: each in_valid advances phase modulo DECIM. A sample is kept only when phase==0 before the increment, so the first sample in RUN is kept. Every other sample is discarded.
- Requantisation of a kept sample, registered in one stage (stage R):
  - t = din + 2^(SHIFT-1), computed at IN_WIDTH+1 bits with no wrap.
  - q = t >>> SHIFT (arithmetic shift; round half toward +inf).
  - If q > 2^(OUT_WIDTH-1)-1, clamp to that value. If q < -2^(OUT_WIDTH-1), clamp to that value.
  - A clamp sets sat_seen.
- FIFO:
  - The stage-R result is written the cycle after it is registered.
  - pop = out_valid & out_ready.
  - A write while full with no pop drops the new sample, sets ovf, and leaves the FIFO contents unchanged.
  - A write while full with a simultaneous pop is accepted and does not set ovf.
  - A pop while empty is ignored.
- clr clears sat_seen and ovf on the next edge. If a set event occurs in the same cycle as clr, the set wins.
- Asserting rst mid-operation clears everything: FIFO contents are lost, and the block re-enters WARMUP and discards WARMUP new samples.
- in_valid=0 freezes the counters and phase. Stage R and the FIFO keep draining.

## Timing
- The kept din is sampled at edge N into stage R. It is written to the FIFO at edge N+1. out_valid rises after edge N+1, i.e. a 2-cycle latency when the FIFO is empty.
- out_data is valid whenever out_valid=1 and holds steady until popped.
- Full throughput: in_valid every cycle with DECIM=1 and out_ready tied high never fills the FIFO.
- Sticky flags assert on the edge at which the causing event is registered: the stage-R edge for sat_seen, the FIFO-write edge for ovf.

## Test plan
- Warm-up discard: reset, then 39 in_valid samples of 1024 → out_valid stays 0. The 40th sample, 2048, gives out_data=2 two cycles later.
- Decimation: in RUN with DECIM=4, drive din=k·1024 for k=0..11 on consecutive cycles → outputs exactly 0, 4, 8 in order.
- Rounding: din=1536 → 2; din=1535 → 1; din=-1536 → -1; din=-1537 → -2; din=511 → 0; din=512 → 1.
- Saturation: din=2^26 → 32767; din=-2^26 → -32768. sat_seen=1 afterwards; clr returns it to 0.
- Back-pressure: out_ready=0 with 9 kept samples of values 1..9 → 8 buffered and ovf=1. Releasing out_ready yields 1..8, then out_valid=0.
  - Repeat with a pop in the same cycle as the 9th write → ovf stays 0.
- Reset mid-run: with 3 samples buffered, pulse rst → out_valid=0 and flags 0 immediately. The next 39 samples produce no output.
